// File: rtl/mod_period_detect.sv
// Period detector: measures the waveform period (in valid samples) between
// successive rising zero crossings, using a symmetric hysteresis band.
module mod_period_detect #(
    parameter logic signed [31:0] HYST       = 32'sd4096,
    parameter logic        [31:0] MAX_PERIOD = 32'd1_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic signed [31:0] i_sample,
    input  logic               i_valid,
    output logic        [31:0] o_period,
    output logic               o_period_valid,
    output logic               o_locked,
    output logic               o_timeout
);

    typedef enum logic [1:0] {
        S_SEEK_LOW = 2'd0,
        S_ARMED    = 2'd1,
        S_MEASURE  = 2'd2
    } state_e;

    // Lower threshold formed in 33 bits so negating any positive HYST is exact.
    localparam logic signed [32:0] NEG_HYST = -$signed({HYST[31], HYST});

    state_e             state_q;
    logic        [31:0] cnt_q;
    logic               pol_q;
    logic        [31:0] period_q;
    logic               period_valid_q;
    logic               locked_q;
    logic               timeout_q;

    logic signed [32:0] sample_ext_c;
    logic               is_high_c;
    logic               is_low_c;
    logic               rise_c;
    logic        [31:0] cnt_inc_c;
    logic               at_max_c;

    // Threshold classification of the incoming sample and counter lookahead.
    always_comb begin
        sample_ext_c = $signed({i_sample[31], i_sample});
        is_high_c    = (i_sample >= HYST);
        is_low_c     = (sample_ext_c <= NEG_HYST);
        rise_c       = is_high_c && !pol_q;
        cnt_inc_c    = cnt_q + 32'd1;
        at_max_c     = (cnt_inc_c == MAX_PERIOD);
    end

    // Seek/arm/measure sequencer with registered period, lock and pulse outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_SEEK_LOW;
            cnt_q          <= 32'd0;
            pol_q          <= 1'b0;
            period_q       <= 32'd0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            if (i_clear) begin
                state_q  <= S_SEEK_LOW;
                cnt_q    <= 32'd0;
                pol_q    <= 1'b0;
                locked_q <= 1'b0;
            end else if (i_valid) begin
                case (state_q)
                    S_SEEK_LOW: begin
                        // Waiting for a negative half so a mid-positive start is not an edge.
                        if (is_low_c) begin
                            pol_q   <= 1'b0;
                            state_q <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        // First rising edge is only the reference point.
                        if (rise_c) begin
                            pol_q   <= 1'b1;
                            cnt_q   <= 32'd0;
                            state_q <= S_MEASURE;
                        end else if (is_low_c) begin
                            pol_q <= 1'b0;
                        end
                    end
                    S_MEASURE: begin
                        if (rise_c) begin
                            // An edge on the last allowed sample still counts as a period.
                            pol_q          <= 1'b1;
                            period_q       <= cnt_inc_c;
                            period_valid_q <= 1'b1;
                            locked_q       <= 1'b1;
                            cnt_q          <= 32'd0;
                        end else begin
                            if (is_low_c) begin
                                pol_q <= 1'b0;
                            end
                            if (at_max_c) begin
                                timeout_q <= 1'b1;
                                locked_q  <= 1'b0;
                                cnt_q     <= 32'd0;
                                state_q   <= S_SEEK_LOW;
                            end else begin
                                cnt_q <= cnt_inc_c;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_SEEK_LOW;
                        cnt_q   <= 32'd0;
                    end
                endcase
            end
        end
    end

    assign o_period       = period_q;
    assign o_period_valid = period_valid_q;
    assign o_locked       = locked_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_mod_period_detect.sv
// Scoreboard bench for mod_period_detect: stimulus pushes expected pulses,
// a negedge monitor pops and compares whenever a DUT presents a pulse.
module tb_mod_period_detect;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               clear   = 1'b0;
    logic               valid_a = 1'b0;
    logic               valid_b = 1'b0;
    logic signed [31:0] sample  = 32'sd0;

    logic [31:0] per_a, per_b;
    logic        pv_a, lk_a, to_a;
    logic        pv_b, lk_b, to_b;

    // Main instance: long timeout so only real measurements appear.
    mod_period_detect #(.HYST(32'sd4096), .MAX_PERIOD(32'd1000)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_sample(sample),
        .i_valid(valid_a), .o_period(per_a), .o_period_valid(pv_a),
        .o_locked(lk_a), .o_timeout(to_a)
    );

    // Timeout instance with MAX_PERIOD = 50.
    mod_period_detect #(.HYST(32'sd4096), .MAX_PERIOD(32'd50)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_sample(sample),
        .i_valid(valid_b), .o_period(per_b), .o_period_valid(pv_b),
        .o_locked(lk_b), .o_timeout(to_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_to;
        logic [31:0] period;
        logic        locked;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   sel_b    = 1'b0;

    int pat3 [20] = '{1000, -1000, 5000, 3000, 5000, 3000, 5000, 3000, 5000, 3000,
                      -1000, 1000, -5000, -3000, -5000, -3000, -5000, -3000, -5000, -3000};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic judge(string nm, logic pv, logic to, logic [31:0] per, logic lk,
                         bit have, exp_t e);
        n_checks++;
        if (!have)
            $display("FAIL %s unexpected pulse: pv=%0d to=%0d period=%0d locked=%0d",
                     nm, pv, to, per, lk);
        else if (pv == !e.is_to && to == e.is_to && per == e.period && lk == e.locked)
            n_pass++;
        else
            $display("FAIL %s pulse: got pv=%0d to=%0d period=%0d locked=%0d expected to=%0d period=%0d locked=%0d",
                     nm, pv, to, per, lk, e.is_to, e.period, e.locked);
    endtask

    // Monitor: any pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (pv_a || to_a) begin
            have = (qa.size() > 0);
            e    = have ? qa.pop_front() : '0;
            judge("dut_a", pv_a, to_a, per_a, lk_a, have, e);
        end
        if (pv_b || to_b) begin
            have = (qb.size() > 0);
            e    = have ? qb.pop_front() : '0;
            judge("dut_b", pv_b, to_b, per_b, lk_b, have, e);
        end
    end

    task automatic expect_p(logic [31:0] p);
        exp_t e;
        e = '{is_to: 1'b0, period: p, locked: 1'b1};
        if (sel_b) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic expect_to(logic [31:0] last);
        exp_t e;
        e = '{is_to: 1'b1, period: last, locked: 1'b0};
        if (sel_b) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic send(logic signed [31:0] s);
        sample  = s;
        valid_a = !sel_b;
        valid_b = sel_b;
        @(posedge clk); #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    // Idle cycles carry a large value to show invalid samples are ignored.
    task automatic idle(int n);
        sample = 32'sd30000;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic square20(int last_j);
        for (int j = 0; j <= last_j; j++) begin
            if (j >= 40 && j % 20 == 0) expect_p(32'd20);
            send((j % 20 < 10) ? 32'sd8000 : -32'sd8000);
        end
    endtask

    function automatic int sine_s(int k);
        return $rtoi(20000.0 * $sin(6.283185307179586 * real'(k) / 100.0));
    endfunction

    initial begin
        // Reset state
        #2;
        chk("reset period", per_a, 32'd0);
        chk("reset locked", 32'(lk_a), 32'd0);
        chk("reset pv", 32'(pv_a), 32'd0);
        chk("reset timeout", 32'(to_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Square wave, period 16
        for (int k = 0; k < 80; k++) begin
            if (k >= 32 && k % 16 == 0) expect_p(32'd16);
            send((k % 16 < 8) ? 32'sd8000 : -32'sd8000);
        end
        idle(2);
        chk("t1 locked", 32'(lk_a), 32'd1);
        chk("t1 period", per_a, 32'd16);
        do_clear();
        chk("t1 clear locked", 32'(lk_a), 32'd0);
        chk("t1 clear period kept", per_a, 32'd16);

        // Sine, period 100, valid one cycle in three
        for (int k = 0; k < 600; k++) begin
            if (k >= 200 && k % 100 == 4) expect_p(32'd100);
            send(sine_s(k));
            idle(2);
        end
        chk("t2 period", per_a, 32'd100);
        do_clear();

        // Chatter inside the hysteresis band
        for (int k = 0; k < 100; k++) begin
            if (k >= 40 && k % 20 == 2) expect_p(32'd20);
            send(pat3[k % 20]);
        end
        idle(2);
        chk("t3 period", per_a, 32'd20);
        do_clear();

        // Start mid-positive, then square period 20
        for (int k = 0; k < 10; k++) send(32'sd20000);
        square20(105);
        idle(1);
        chk("t4 locked", 32'(lk_a), 32'd1);

        // Clear mid-measurement, then full relock
        do_clear();
        chk("t6 clear locked", 32'(lk_a), 32'd0);
        chk("t6 clear period", per_a, 32'd20);
        square20(45);
        chk("t6 relock after clear", 32'(lk_a), 32'd1);

        // Asynchronous reset mid-measurement
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst period", per_a, 32'd0);
        chk("t6 rst locked", 32'(lk_a), 32'd0);
        chk("t6 rst pv", 32'(pv_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        square20(45);
        chk("t6 relock after reset", 32'(lk_a), 32'd1);
        chk("t6 period after reset", per_a, 32'd20);

        // Timeout with MAX_PERIOD = 50
        sel_b = 1'b1;
        square20(40);
        for (int k = 1; k <= 50; k++) begin
            if (k == 50) expect_to(32'd20);
            send(32'sd0);
        end
        idle(1);
        chk("t5 timeout locked", 32'(lk_b), 32'd0);
        chk("t5 timeout period kept", per_b, 32'd20);
        for (int k = 0; k < 5; k++) send(32'sd0);

        // Edge exactly on the 50th sample wins over timeout
        square20(40);
        for (int k = 1; k <= 49; k++) send(-32'sd8000);
        expect_p(32'd50);
        send(32'sd8000);
        idle(1);
        chk("t5 edge at max locked", 32'(lk_b), 32'd1);
        chk("t5 edge at max period", per_b, 32'd50);
        for (int k = 0; k < 3; k++) send(-32'sd8000);
        sel_b = 1'b0;

        idle(3);
        chk("dut_a pulses outstanding", 32'(qa.size()), 32'd0);
        chk("dut_b pulses outstanding", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
